// File: rtl/matres_pkg.sv
// Shared types and constants for the matrix-result serializer.
// Accumulation mode is built in when MATRES_ACCUM_EN is defined.
package matres_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ACC_FRAMES_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SEND  = 2'd2
   } state_t;

   localparam logic signed [DATA_W_DEF-1:0] SAT_MAX =
      {1'b0, {(DATA_W_DEF-1){1'b1}}};
   localparam logic signed [DATA_W_DEF-1:0] SAT_MIN =
      {1'b1, {(DATA_W_DEF-1){1'b0}}};

endpackage

// File: rtl/matres_sat_add.sv
// Signed saturating adder; ovf flags a clamped result.
// Used by matres_serializer only when MATRES_ACCUM_EN is defined.
module matres_sat_add
   import matres_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [DATA_W-1:0] sum,
   output logic                     ovf
);

   localparam logic signed [DATA_W-1:0] MAX = (DATA_W == DATA_W_DEF) ?
      DATA_W'(SAT_MAX) : {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] MIN = (DATA_W == DATA_W_DEF) ?
      DATA_W'(SAT_MIN) : {1'b1, {(DATA_W-1){1'b0}}};

   logic signed [DATA_W-1:0] raw;

   assign raw = a + b;
   // Overflow only when both operands share a sign the result lost
   assign ovf = (a[DATA_W-1] == b[DATA_W-1]) &&
                (raw[DATA_W-1] != a[DATA_W-1]);
   assign sum = ovf ? (a[DATA_W-1] ? MIN : MAX) : raw;

endmodule

// File: rtl/matres_serializer.sv
// Serializes 2x2 result frames into r1..r4 words over a valid/ready link.
// Define MATRES_ACCUM_EN to sum ACC_FRAMES frames per burst with saturation.
module matres_serializer
   import matres_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ACC_FRAMES = ACC_FRAMES_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] r1,
   input  logic signed [DATA_W-1:0] r2,
   input  logic signed [DATA_W-1:0] r3,
   input  logic signed [DATA_W-1:0] r4,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               out_idx,
   output logic                     out_last,
   output logic                     sat
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_SEND = SEND;

   if (ACC_FRAMES < 1 || ACC_FRAMES > 255) begin : g_bad_acc
      $error("ACC_FRAMES must be in 1..255");
   end

   logic [1:0]               state;
   logic [1:0]               idx;
   logic signed [DATA_W-1:0] words [4];
   logic signed [DATA_W-1:0] frame [4];
   logic                     in_fire;
   logic                     out_fire;

   assign frame = '{r1, r2, r3, r4};

   always_comb begin
      in_ready = 1'b1;
      unique case (state)
         ST_SEND: in_ready = (idx == 2'd3) && out_ready;
         default: in_ready = 1'b1;
      endcase
   end

   assign out_valid = (state == ST_SEND);
   assign out_idx   = idx;
   assign out_data  = words[idx];
   assign out_last  = out_valid && (idx == 2'd3);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

`ifdef MATRES_ACCUM_EN
   localparam logic [1:0] ST_ACCUM = ACCUM;

   logic signed [DATA_W-1:0] acc [4];
   logic signed [DATA_W-1:0] sum [4];
   logic [3:0]               ovf;
   logic [7:0]               cnt;
   logic [8:0]               cnt_nx;
   logic                     done;
   logic                     sat_q;

   for (genvar i = 0; i < 4; i++) begin : g_add
      matres_sat_add #(.DATA_W(DATA_W)) u_add (
         .a   (acc[i]),
         .b   (frame[i]),
         .sum (sum[i]),
         .ovf (ovf[i])
      );
   end

   assign cnt_nx = {1'b0, cnt} + 9'd1;
   assign done   = (cnt_nx >= 9'(ACC_FRAMES));
   assign sat    = sat_q;

   // Accumulators are zero whenever a burst is loaded, so an overlapping
   // frame naturally seeds them with count 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '{default: '0};
         cnt   <= '0;
         sat_q <= 1'b0;
      end else if (in_fire) begin
         sat_q <= sat_q | (|ovf);
         if (done) begin
            acc <= '{default: '0};
            cnt <= '0;
         end else begin
            acc <= sum;
            cnt <= cnt_nx[7:0];
         end
      end
   end
`else
   assign sat = 1'b0;
`endif

   // A new frame wins over the last-word advance: no bubble between bursts
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         idx   <= '0;
         words <= '{default: '0};
      end else if (in_fire) begin
         idx <= '0;
`ifdef MATRES_ACCUM_EN
         if (done) begin
            words <= sum;
            state <= ST_SEND;
         end else begin
            state <= ST_ACCUM;
         end
`else
         words <= frame;
         state <= ST_SEND;
`endif
      end else if (out_fire) begin
         idx <= idx + 2'd1;
         if (idx == 2'd3) state <= ST_IDLE;
      end
   end

endmodule

// File: tb/tb_matres_serializer.sv
// Self-checking bench for matres_serializer with a word scoreboard.
// Builds for both plain and MATRES_ACCUM_EN configurations.
module tb_matres_serializer;
   import matres_pkg::*;

   localparam int TB_ACC = 4;
`ifdef MATRES_ACCUM_EN
   localparam int NF = TB_ACC;
`else
   localparam int NF = 1;
`endif

   typedef struct {
      logic signed [31:0] d;
      logic [1:0]         i;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [31:0] r1, r2, r3, r4;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] out_data;
   logic               out_valid;
   logic               out_ready;
   logic [1:0]         out_idx;
   logic               out_last;
   logic               sat;

   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];

   logic signed [31:0] m_acc [4];
   int                 m_cnt;
   logic               m_sat;

   always #5 clk = ~clk;

   matres_serializer #(.DATA_W(32), .ACC_FRAMES(TB_ACC)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .r1        (r1),
      .r2        (r2),
      .r3        (r3),
      .r4        (r4),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .sat       (sat)
   );

   // Scoreboard: every transferred word must match the next expected one
   always @(negedge clk) begin
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL word_extra: got data=%0d idx=%0d, none expected",
                     out_data, out_idx);
         end else begin
            e = exp_q.pop_front();
            if (out_data !== e.d || out_idx !== e.i ||
                out_last !== (e.i == 2'd3)) begin
               failures++;
               $display("FAIL word: got data=%0d idx=%0d last=%0b, want data=%0d idx=%0d last=%0b",
                        out_data, out_idx, out_last, e.d, e.i, (e.i == 2'd3));
            end
         end
      end
   end

   function automatic logic signed [31:0] sadd(input logic signed [31:0] a,
                                                input logic signed [31:0] b,
                                                output logic o);
      longint s;
      s = longint'(a) + longint'(b);
      o = 1'b0;
      if (s > 64'sd2147483647) begin
         o = 1'b1;
         return 32'sh7FFFFFFF;
      end
      if (s < -64'sd2147483648) begin
         o = 1'b1;
         return 32'sh80000000;
      end
      return 32'(s);
   endfunction

   task automatic model_clear();
      exp_q.delete();
      m_acc = '{default: '0};
      m_cnt = 0;
      m_sat = 1'b0;
   endtask

   task automatic model_accept(input logic signed [31:0] a, b, c, d);
      logic signed [31:0] f [4];
      logic o;
      f = '{a, b, c, d};
`ifdef MATRES_ACCUM_EN
      for (int i = 0; i < 4; i++) begin
         m_acc[i] = sadd(m_acc[i], f[i], o);
         m_sat = m_sat | o;
      end
      m_cnt++;
      if (m_cnt == TB_ACC) begin
         for (int i = 0; i < 4; i++) exp_q.push_back('{d: m_acc[i], i: 2'(i)});
         m_acc = '{default: '0};
         m_cnt = 0;
      end
`else
      o = 1'b0;
      for (int i = 0; i < 4; i++) exp_q.push_back('{d: f[i], i: 2'(i)});
`endif
   endtask

   // Starts and ends at posedge+1; returns right after the transfer edge
   task automatic send_frame(input logic signed [31:0] a, b, c, d);
      bit ok = 0;
      r1 = a; r2 = b; r3 = c; r4 = d;
      in_valid = 1'b1;
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (ok) model_accept(a, b, c, d);
      else begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready=%0b, want 1 within 64 cycles", in_ready);
      end
   endtask

   task automatic drain(input string name);
      bit ok = 0;
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_drain: pending=%0d out_valid=%0b, want 0 and 0",
                  name, exp_q.size(), out_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid: got %0b want 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got %0b want 1", in_ready);
      end
      checks++;
      if (out_idx !== 2'd0) begin
         failures++;
         $display("FAIL reset_idx: got %0d want 0", out_idx);
      end
      checks++;
      if (out_data !== 32'sd0) begin
         failures++;
         $display("FAIL reset_data: got %0d want 0", out_data);
      end
      checks++;
      if (out_last !== 1'b0) begin
         failures++;
         $display("FAIL reset_last: got %0b want 0", out_last);
      end
      checks++;
      if (sat !== 1'b0) begin
         failures++;
         $display("FAIL reset_sat: got %0b want 0", sat);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_bypass();
      int base [4] = '{19, 22, 43, 50};
      out_ready = 1'b1;
      for (int f = 0; f < NF; f++) send_frame(19, 22, 43, 50);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'(base[k] * NF) ||
             out_idx !== 2'(k) || out_last !== (k == 3)) begin
            failures++;
            $display("FAIL bypass_w%0d: got v=%0b d=%0d i=%0d l=%0b, want v=1 d=%0d i=%0d l=%0b",
                     k, out_valid, out_data, out_idx, out_last,
                     base[k] * NF, k, (k == 3));
         end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bypass_idle: got out_valid=%0b want 0", out_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b1;
      for (int f = 0; f < NF; f++) send_frame(19, 22, 43, 50);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'(22 * NF) || out_idx !== 2'd1) begin
            failures++;
            $display("FAIL stall_hold%0d: got v=%0b d=%0d i=%0d, want v=1 d=%0d i=1",
                     k, out_valid, out_data, out_idx, 22 * NF);
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain("stall");
   endtask

`ifndef MATRES_ACCUM_EN
   task automatic test_back_to_back();
      logic signed [31:0] b [4] = '{-5, -10, -11, -2};
      bit ok = 0;
      out_ready = 1'b1;
      r1 = 1; r2 = 0; r3 = 0; r4 = 0;
      in_valid = 1'b1;
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL b2b_accept: in_ready=%0b want 1", in_ready);
      end
      @(posedge clk);
      #1;
      model_accept(1, 0, 0, 0);
      r1 = b[0]; r2 = b[1]; r3 = b[2]; r4 = b[3];
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_idx !== 2'(k) || in_ready !== (k == 3)) begin
            failures++;
            $display("FAIL b2b_a%0d: got v=%0b i=%0d rdy=%0b, want v=1 i=%0d rdy=%0b",
                     k, out_valid, out_idx, in_ready, k, (k == 3));
         end
      end
      @(posedge clk);
      #1;
      model_accept(b[0], b[1], b[2], b[3]);
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_idx !== 2'(k) || out_data !== b[k] ||
             in_ready !== (k == 3)) begin
            failures++;
            $display("FAIL b2b_b%0d: got v=%0b i=%0d d=%0d rdy=%0b, want v=1 i=%0d d=%0d rdy=%0b",
                     k, out_valid, out_idx, out_data, in_ready, k, b[k], (k == 3));
         end
      end
      drain("b2b");
   endtask
`endif

`ifdef MATRES_ACCUM_EN
   task automatic test_accum();
      out_ready = 1'b1;
      for (int f = 0; f < TB_ACC; f++) begin
         send_frame(1, 2, 3, 4);
         if (f < TB_ACC - 1) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
               failures++;
               $display("FAIL accum_quiet%0d: got out_valid=%0b want 0", f, out_valid);
            end
            @(posedge clk);
            #1;
         end
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(TB_ACC) || out_idx !== 2'd0) begin
         failures++;
         $display("FAIL accum_first: got v=%0b d=%0d i=%0d, want v=1 d=%0d i=0",
                  out_valid, out_data, out_idx, TB_ACC);
      end
      drain("accum");
   endtask

   task automatic test_sat();
      out_ready = 1'b1;
      send_frame(32'sh7FFFFFF0, 0, 0, 0);
      send_frame(32'sh00000100, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (sat !== 1'b1) begin
         failures++;
         $display("FAIL sat_set: got %0b want 1", sat);
      end
      @(posedge clk);
      #1;
      for (int f = 2; f < TB_ACC; f++) send_frame(0, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (out_data !== 32'sh7FFFFFFF) begin
         failures++;
         $display("FAIL sat_word: got %0h want 7fffffff", out_data);
      end
      drain("sat1");
      for (int f = 0; f < TB_ACC; f++) send_frame(1, 1, 1, 1);
      drain("sat2");
      checks++;
      if (sat !== m_sat) begin
         failures++;
         $display("FAIL sat_sticky: got %0b want %0b", sat, m_sat);
      end
   endtask
`endif

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      for (int f = 0; f < NF; f++) send_frame(7, 8, 9, 10);
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_idx !== 2'd2) begin
         failures++;
         $display("FAIL rmid_pre: got idx=%0d want 2", out_idx);
      end
      pulse_reset();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || sat !== 1'b0 || out_idx !== 2'd0) begin
         failures++;
         $display("FAIL rmid_post: got v=%0b rdy=%0b sat=%0b i=%0d, want v=0 rdy=1 sat=0 i=0",
                  out_valid, in_ready, sat, out_idx);
      end
      @(posedge clk);
      #1;
`ifdef MATRES_ACCUM_EN
      send_frame(100, 100, 100, 100);
      pulse_reset();
`endif
      for (int f = 0; f < NF; f++) send_frame(5, 6, 7, 8);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_data !== 32'(5 * NF)) begin
         failures++;
         $display("FAIL rmid_restart: got v=%0b i=%0d d=%0d, want v=1 i=0 d=%0d",
                  out_valid, out_idx, out_data, 5 * NF);
      end
      drain("rmid");
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      r1 = '0; r2 = '0; r3 = '0; r4 = '0;
      model_clear();
      test_reset();
      test_bypass();
      test_backpressure();
`ifndef MATRES_ACCUM_EN
      test_back_to_back();
`else
      test_accum();
      test_sat();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/matres_serializer.md
MATRES_SERIALIZER -- requirements
Module: matres_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of each result word.
REQ-002 SHALL have parameter ACC_FRAMES, default 4, meaning the number of frames summed per output burst; legal range 1..255; used only with MATRES_ACCUM_EN.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports r1, r2, r3, r4, input, DATA_W bits each, signed: the 2x2 matrix-product frame from the upstream multiplier, row-major.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the frame handshake; a frame transfers on a rising edge when both are 1.
REQ-007 SHALL have port out_data, output, DATA_W bits, signed: the current serialized word.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the word handshake; a word transfers when both are 1.
REQ-009 SHALL have port out_idx, output, 2 bits: the index of the current word (0 = r1 ... 3 = r4).
REQ-010 SHALL have port out_last, output, 1 bit: 1 exactly when out_valid=1 and out_idx=3.
REQ-011 SHALL have port sat, output, 1 bit: sticky saturation flag.

Function
REQ-012 SHALL implement the state machine states IDLE and SEND, plus ACCUM when MATRES_ACCUM_EN is defined.
REQ-013 In IDLE: in_ready=1 and out_valid=0; a frame transfer captures r1..r4 into the word buffer and moves to SEND with out_idx=0 (bypass path).
REQ-014 In SEND: out_valid=1 and out_data=buf[out_idx]; each word transfer increments out_idx; out_data and out_idx SHALL hold stable while out_valid=1 and out_ready=0.
REQ-015 A word transfer at out_idx=3 returns to IDLE, unless a frame transfers in the same cycle.
REQ-016 In SEND, in_ready SHALL equal (out_idx==3 && out_ready), driven combinationally.
REQ-017 When a frame transfers in the same cycle as the last word: the new frame is captured, and SEND restarts at out_idx=0 (bypass) or ACCUM is entered; there SHALL be no bubble cycle.
REQ-018 Latency: the first word is valid on the cycle after the frame transfer. Sustained bypass throughput is one frame per 4 cycles when out_ready is held at 1.
REQ-019 Word order SHALL always be r1, r2, r3, r4, with no reordering or skipping.
REQ-020 in_valid while in_ready=0 SHALL be ignored; no data is lost, because upstream holds the frame.

Reset
REQ-021 On rst=1 at a rising edge, the block SHALL set state=IDLE, out_idx=0, out_data=0, buffer and accumulators=0, frame counter=0, sat=0.
REQ-022 Reset mid-burst or mid-accumulation SHALL discard the partial burst or sum. Outputs are at reset values in the cycle after reset; in_ready=1 from that cycle.

Configuration
REQ-023 Macro MATRES_ACCUM_EN SHALL select the accumulation feature.
REQ-024 With MATRES_ACCUM_EN defined:
- Each accepted frame is added element-wise into four DATA_W signed accumulators using saturating addition.
- An 8-bit frame counter increments per frame.
- The state is ACCUM while the counter < ACC_FRAMES; in_ready=1 in ACCUM.
- On the ACC_FRAMES-th frame, the sums (including that frame) load into the buffer, the accumulators and counter clear, and the state goes to SEND.
- A frame overlapping the last word (REQ-017) seeds the accumulators with that frame and counter=1.
- ACC_FRAMES=1 SHALL behave identically to bypass.
REQ-025 Any saturation SHALL set sat, which is cleared only by rst.
REQ-026 Without MATRES_ACCUM_EN: no accumulator or counter logic is present, every frame is serialized directly, and sat is tied to 0.

Structure
REQ-027 Package matres_pkg SHALL hold:
- the DATA_W default;
- the ACC_FRAMES default;
- the state enum type (IDLE, ACCUM, SEND);
- constants for the signed saturation limits (max, min).
REQ-028 Sub-module matres_sat_add (DATA_W signed saturating adder with overflow flag) SHALL be instantiated four times under MATRES_ACCUM_EN.

Verification
REQ-029 Bypass, out_ready=1: frame (19,22,43,50) -> words 19, 22, 43, 50 on four consecutive cycles starting the cycle after transfer; out_idx 0..3; out_last only on 50.
REQ-030 Backpressure: out_ready=0 for 3 cycles at out_idx=1 -> out_data holds 22 and out_idx holds 1; the burst completes after release with no duplicate words.
REQ-031 Back-to-back: in_valid held with frames (1,0,0,0) then (-5,-10,-11,-2) and out_ready=1 -> 8 words on 8 consecutive cycles; in_ready pulses only in the out_idx=3 cycle.
REQ-032 Accumulate (macro, ACC_FRAMES=4): four frames of (1,2,3,4) -> one burst of 4, 8, 12, 16; no output during the first three frames.
REQ-033 Saturation (macro, ACC_FRAMES=2): frames r1=0x7FFFFFF0, then r1=0x100 -> word 0x7FFFFFFF and sat=1, which stays 1 through later frames.
REQ-034 Reset mid-burst at out_idx=2 -> the next cycle shows out_valid=0, in_ready=1, sat=0; the next frame serializes from out_idx=0.
